// File: rtl/tx_storage_fifo.sv
// Transmit frame buffer: 64-deep FIFO of formatted CAN frames.
// Head frame is offered to the engine until it reports a successful send.
module tx_storage_fifo #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 6
) (
  input  logic              sys_clk,
  input  logic              IP2Can_reset,
  input  logic              load_data1,
  input  logic [DATA_W-1:0] txfifo_ip,
  input  logic              tx_flush,
  output logic              tx_req,
  output logic [DATA_W-1:0] txfifo_op,
  input  logic              tx_done,
  input  logic              tx_retry,
  output logic [ADDR_W:0]   count1,
  output logic              TXNEMP,
  output logic              TXFLL,
  output logic              TXOFLW,
  output logic [7:0]        retry_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    OFFER
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   ptr_diff;
  logic              wr_en;
  logic              pop;
  logic              bump;
  logic              fetch;
  logic              ovf_q;

  assign ptr_diff  = wr_ptr - rd_ptr;
  assign count1    = IP2Can_reset ? '0 : ptr_diff;
  assign TXNEMP    = |count1;
  assign TXFLL     = count1[ADDR_W];
  assign TXOFLW    = ovf_q;
  assign tx_req    = (state == OFFER);
  assign wr_en     = load_data1 & ~TXFLL & ~tx_flush & ~IP2Can_reset;

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    bump      = 1'b0;
    fetch     = 1'b0;
    unique case (state)
      IDLE: begin
        if (TXNEMP) state_nxt = FETCH;
      end
      FETCH: begin
        fetch     = 1'b1;
        state_nxt = OFFER;
      end
      OFFER: begin
        if (tx_done) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end else if (tx_retry) begin
          bump = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; flush aborts any offer in progress
  always_ff @(posedge sys_clk) begin
    if (IP2Can_reset)  state <= IDLE;
    else if (tx_flush) state <= IDLE;
    else               state <= state_nxt;
  end

  // Frame storage, not reset
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= txfifo_ip;
  end

  // Read/write pointers with extra wrap bit
  always_ff @(posedge sys_clk) begin
    if (IP2Can_reset || tx_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (ADDR_W+1)'(wr_en);
      rd_ptr <= rd_ptr + (ADDR_W+1)'(pop);
    end
  end

  // Head frame register loaded in FETCH
  always_ff @(posedge sys_clk) begin
    if (IP2Can_reset)
      txfifo_op <= '0;
    else if (fetch && !tx_flush)
      txfifo_op <= mem[rd_ptr[ADDR_W-1:0]];
  end

  // Saturating retry counter for the head frame
  always_ff @(posedge sys_clk) begin
    if (IP2Can_reset || tx_flush)
      retry_cnt <= '0;
    else if (pop)
      retry_cnt <= '0;
    else if (bump && retry_cnt != 8'hFF)
      retry_cnt <= retry_cnt + 8'd1;
  end

  // One-cycle pulse for a write dropped on full
  always_ff @(posedge sys_clk) begin
    if (IP2Can_reset) ovf_q <= 1'b0;
    else              ovf_q <= load_data1 & TXFLL & ~tx_flush;
  end

endmodule
